// File: rtl/alu_muldiv_if.sv
// Operand/result bundle for alu_muldiv. The master side drives operands and
// the start request; the slave side (the ALU) returns the registered result,
// flags and the busy/done status.
interface alu_muldiv_if #(
  parameter int WIDTH = 16
) ();
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [4:0]       aluOp;
  logic             execute;
  logic [WIDTH-1:0] aluOut;
  logic             C;
  logic             Z;
  logic             S;
  logic             V;
  logic             busy;
  logic             done;

  modport master (
    output A, B, aluOp, execute,
    input  aluOut, C, Z, S, V, busy, done
  );

  modport slave (
    input  A, B, aluOp, execute,
    output aluOut, C, Z, S, V, busy, done
  );
endinterface

// File: rtl/alu_muldiv.sv
// alu_muldiv: single-cycle ALU with an iterative shift-add multiplier and an
// optional restoring divider. Results and flags are registered; done pulses
// for one cycle whenever an accepted operation completes.
// Build option: define ALU_MULDIV_DIV_EN to include DIVU/REMU; without it
// opcodes 10/11 are treated as no-ops and the divider is not built.
module alu_muldiv #(
  parameter int WIDTH = 16
) (
  input  logic          CLK,
  input  logic          RSTb,
  alu_muldiv_if.slave   bus
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [4:0] OP_MOV   = 5'd0;
  localparam logic [4:0] OP_ADD   = 5'd1;
  localparam logic [4:0] OP_ADC   = 5'd2;
  localparam logic [4:0] OP_SUB   = 5'd3;
  localparam logic [4:0] OP_SBB   = 5'd4;
  localparam logic [4:0] OP_AND   = 5'd5;
  localparam logic [4:0] OP_OR    = 5'd6;
  localparam logic [4:0] OP_XOR   = 5'd7;
  localparam logic [4:0] OP_MUL   = 5'd8;
  localparam logic [4:0] OP_MULHU = 5'd9;
  localparam logic [4:0] OP_CMP   = 5'd12;
  localparam logic [4:0] OP_TEST  = 5'd13;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1
`ifdef ALU_MULDIV_DIV_EN
    , ST_DIV = 2'd2
`endif
  } state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] out_r;
  logic             c_r, z_r, s_r, v_r, done_r;

  logic             accept, last, is_mul, is_div, is_multi;

  // Single-cycle datapath results
  logic [WIDTH:0]   sum, dif;
  logic             add_v, sub_v;
  logic [WIDTH-1:0] sc_res;
  logic             sc_c, sc_v, sc_wr_out, sc_wr_flg;

  // Iterative datapath state (operands captured at accept)
  logic [WIDTH-1:0] mcand, prod_hi, prod_lo;
  logic [WIDTH-1:0] hi_nxt, lo_nxt;
  logic [WIDTH:0]   mul_sum;
  logic             hi_sel;
  logic [WIDTH-1:0] mc_res;
  logic             mc_v;

`ifdef ALU_MULDIV_DIV_EN
  logic [WIDTH-1:0] dvsr, dvnd, rem, quo, rem_nxt, quo_nxt;
  logic [WIDTH:0]   shifted, trial;
`endif

  assign accept = bus.execute && (state == ST_IDLE);
  assign last   = (cnt == CW'(WIDTH - 1));
  assign is_mul = (bus.aluOp == OP_MUL) || (bus.aluOp == OP_MULHU);
`ifdef ALU_MULDIV_DIV_EN
  assign is_div = (bus.aluOp == 5'd10) || (bus.aluOp == 5'd11);
`else
  assign is_div = 1'b0;
`endif
  assign is_multi = is_mul || is_div;

  // Single-cycle result/flag selection; CMP and TEST compute but do not write aluOut
  always_comb begin
    sum   = {1'b0, bus.A} + {1'b0, bus.B} + {{WIDTH{1'b0}}, (bus.aluOp == OP_ADC) & c_r};
    dif   = {1'b0, bus.A} - {1'b0, bus.B} - {{WIDTH{1'b0}}, (bus.aluOp == OP_SBB) & c_r};
    add_v = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) && (sum[WIDTH-1] != bus.A[WIDTH-1]);
    sub_v = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) && (dif[WIDTH-1] != bus.A[WIDTH-1]);
    sc_res    = '0;
    sc_c      = 1'b0;
    sc_v      = 1'b0;
    sc_wr_out = 1'b0;
    sc_wr_flg = 1'b0;
    case (bus.aluOp)
      OP_MOV: begin
        sc_res = bus.B; sc_wr_out = 1'b1; sc_wr_flg = 1'b1;
      end
      OP_ADD, OP_ADC: begin
        sc_res = sum[WIDTH-1:0]; sc_c = sum[WIDTH]; sc_v = add_v;
        sc_wr_out = 1'b1; sc_wr_flg = 1'b1;
      end
      OP_SUB, OP_SBB, OP_CMP: begin
        sc_res = dif[WIDTH-1:0]; sc_c = dif[WIDTH]; sc_v = sub_v;
        sc_wr_out = (bus.aluOp != OP_CMP); sc_wr_flg = 1'b1;
      end
      OP_AND, OP_TEST: begin
        sc_res = bus.A & bus.B;
        sc_wr_out = (bus.aluOp == OP_AND); sc_wr_flg = 1'b1;
      end
      OP_OR: begin
        sc_res = bus.A | bus.B; sc_wr_out = 1'b1; sc_wr_flg = 1'b1;
      end
      OP_XOR: begin
        sc_res = bus.A ^ bus.B; sc_wr_out = 1'b1; sc_wr_flg = 1'b1;
      end
      default: ;
    endcase
  end

  // One shift-add step: add multiplicand when the current multiplier bit is set
  always_comb begin
    mul_sum = {1'b0, prod_hi} + (prod_lo[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
    hi_nxt  = mul_sum[WIDTH:1];
    lo_nxt  = {mul_sum[0], prod_lo[WIDTH-1:1]};
  end

`ifdef ALU_MULDIV_DIV_EN
  // One restoring-division step: keep the trial difference when it does not borrow
  always_comb begin
    shifted = {rem, quo[WIDTH-1]};
    trial   = shifted - {1'b0, dvsr};
    if (!trial[WIDTH]) begin
      rem_nxt = trial[WIDTH-1:0];
      quo_nxt = {quo[WIDTH-2:0], 1'b1};
    end else begin
      rem_nxt = shifted[WIDTH-1:0];
      quo_nxt = {quo[WIDTH-2:0], 1'b0};
    end
  end
`endif

  // Final multi-cycle result, taken from the step completing on the last edge
  always_comb begin
    mc_res = hi_sel ? hi_nxt : lo_nxt;
    mc_v   = 1'b0;
`ifdef ALU_MULDIV_DIV_EN
    if (state == ST_DIV) begin
      if (dvsr == '0) begin
        mc_res = hi_sel ? dvnd : {WIDTH{1'b1}};
        mc_v   = 1'b1;
      end else begin
        mc_res = hi_sel ? rem_nxt : quo_nxt;
      end
    end
`endif
  end

  // Control FSM next state
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept && is_mul) state_nxt = ST_MUL;
`ifdef ALU_MULDIV_DIV_EN
        else if (accept && is_div) state_nxt = ST_DIV;
`endif
      end
      ST_MUL: if (last) state_nxt = ST_IDLE;
`ifdef ALU_MULDIV_DIV_EN
      ST_DIV: if (last) state_nxt = ST_IDLE;
`endif
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Control FSM state register
  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Iteration counter, registered result, flags and completion pulse
  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      cnt    <= '0;
      out_r  <= '0;
      c_r    <= 1'b0;
      z_r    <= 1'b0;
      s_r    <= 1'b0;
      v_r    <= 1'b0;
      done_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (accept) begin
        cnt <= '0;
        if (!is_multi) begin
          done_r <= 1'b1;
          if (sc_wr_out) out_r <= sc_res;
          if (sc_wr_flg) begin
            c_r <= sc_c;
            z_r <= (sc_res == '0);
            s_r <= sc_res[WIDTH-1];
            v_r <= sc_v;
          end
        end
      end else if (state != ST_IDLE) begin
        cnt <= cnt + CW'(1);
        if (last) begin
          cnt    <= '0;
          done_r <= 1'b1;
          out_r  <= mc_res;
          c_r    <= 1'b0;
          z_r    <= (mc_res == '0);
          s_r    <= mc_res[WIDTH-1];
          v_r    <= mc_v;
        end
      end
    end
  end

  // Operand capture and per-cycle iteration registers (datapath, no reset)
  always_ff @(posedge CLK) begin
    if (accept) begin
      mcand   <= bus.A;
      prod_hi <= '0;
      prod_lo <= bus.B;
      hi_sel  <= bus.aluOp[0];
`ifdef ALU_MULDIV_DIV_EN
      dvsr    <= bus.B;
      dvnd    <= bus.A;
      rem     <= '0;
      quo     <= bus.A;
`endif
    end else if (state == ST_MUL) begin
      prod_hi <= hi_nxt;
      prod_lo <= lo_nxt;
    end
`ifdef ALU_MULDIV_DIV_EN
    else if (state == ST_DIV) begin
      rem <= rem_nxt;
      quo <= quo_nxt;
    end
`endif
  end

  assign bus.aluOut = out_r;
  assign bus.C      = c_r;
  assign bus.Z      = z_r;
  assign bus.S      = s_r;
  assign bus.V      = v_r;
  assign bus.busy   = (state != ST_IDLE);
  assign bus.done   = done_r;

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed testbench for alu_muldiv (WIDTH=16). Results are sampled 1ns after
// the rising edge; each observation packs {aluOut, C, Z, S, V, done}.
module tb_alu_muldiv;
  localparam int W = 16;

  logic CLK = 1'b0;
  logic RSTb = 1'b0;
  int   n_pass = 0;
  int   n_total = 0;

  alu_muldiv_if #(.WIDTH(W)) bus ();
  alu_muldiv #(.WIDTH(W)) dut (.CLK(CLK), .RSTb(RSTb), .bus(bus));

  always #5 CLK = ~CLK;

  function automatic logic [20:0] obs();
    return {bus.aluOut, bus.C, bus.Z, bus.S, bus.V, bus.done};
  endfunction

  // Drive a request now, let one rising edge take it, then drop execute
  task automatic issue(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b);
    bus.aluOp = op; bus.A = a; bus.B = b; bus.execute = 1'b1;
    @(posedge CLK); #1;
    bus.execute = 1'b0;
  endtask

  // Count edges until done; gives up after 40 (the caller's cycle check then fails)
  task automatic wait_done(output int cyc);
    cyc = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge CLK); #1;
      cyc++;
      if (bus.done) break;
    end
  endtask

  task automatic test_reset();
    #7;
    n_total++;
    if ({obs(), bus.busy} !== 22'h0)
      $display("FAIL reset_state: got %h want %h", {obs(), bus.busy}, 22'h0);
    else n_pass++;
    @(negedge CLK); RSTb = 1'b1;
  endtask

  task automatic test_add();
    issue(5'd1, 16'h0005, 16'hFFF9);
    n_total++;
    if (obs() !== {16'hFFFE, 4'b0010, 1'b1})
      $display("FAIL add_basic: got %h want %h", obs(), {16'hFFFE, 4'b0010, 1'b1});
    else n_pass++;
    @(posedge CLK); #1;
    n_total++;
    if (bus.done !== 1'b0) $display("FAIL done_one_cycle: got %b want 0", bus.done);
    else n_pass++;
  endtask

  task automatic test_overflow();
    issue(5'd1, 16'h7FFF, 16'h7FFF);
    n_total++;
    if (obs() !== {16'hFFFE, 4'b0011, 1'b1})
      $display("FAIL add_ovf: got %h want %h", obs(), {16'hFFFE, 4'b0011, 1'b1});
    else n_pass++;
    issue(5'd3, 16'h7FFF, 16'h8000);
    n_total++;
    if (obs() !== {16'hFFFF, 4'b1011, 1'b1})
      $display("FAIL sub_ovf: got %h want %h", obs(), {16'hFFFF, 4'b1011, 1'b1});
    else n_pass++;
  endtask

  task automatic test_carry();
    issue(5'd1, 16'hFFFF, 16'h0001);
    n_total++;
    if (obs() !== {16'h0000, 4'b1100, 1'b1})
      $display("FAIL add_carry: got %h want %h", obs(), {16'h0000, 4'b1100, 1'b1});
    else n_pass++;
    issue(5'd2, 16'h0000, 16'h0000);
    n_total++;
    if (obs() !== {16'h0001, 4'b0000, 1'b1})
      $display("FAIL adc_cin: got %h want %h", obs(), {16'h0001, 4'b0000, 1'b1});
    else n_pass++;
    issue(5'd3, 16'h0000, 16'h0001);
    n_total++;
    if (obs() !== {16'hFFFF, 4'b1010, 1'b1})
      $display("FAIL sub_borrow: got %h want %h", obs(), {16'hFFFF, 4'b1010, 1'b1});
    else n_pass++;
    issue(5'd4, 16'h000A, 16'h0003);
    n_total++;
    if (obs() !== {16'h0006, 4'b0000, 1'b1})
      $display("FAIL sbb_bin: got %h want %h", obs(), {16'h0006, 4'b0000, 1'b1});
    else n_pass++;
  endtask

  task automatic test_logic();
    logic [4:0]  ops [4] = '{5'd0, 5'd5, 5'd6, 5'd7};
    logic [15:0] av  [4] = '{16'hFFFF, 16'hF0F0, 16'hF000, 16'hAAAA};
    logic [15:0] bv  [4] = '{16'h1234, 16'h0FF0, 16'h000F, 16'hAAAA};
    logic [20:0] ex  [4] = '{{16'h1234, 4'b0000, 1'b1}, {16'h00F0, 4'b0000, 1'b1},
                             {16'hF00F, 4'b0010, 1'b1}, {16'h0000, 4'b0100, 1'b1}};
    issue(5'd1, 16'hFFFF, 16'h0001);  // leave C=1 so MOV must clear it
    for (int i = 0; i < 4; i++) begin
      issue(ops[i], av[i], bv[i]);
      n_total++;
      if (obs() !== ex[i]) $display("FAIL logic_op%0d: got %h want %h", ops[i], obs(), ex[i]);
      else n_pass++;
    end
  endtask

  task automatic test_cmp_test_noop();
    issue(5'd0, 16'h0000, 16'h5555);
    issue(5'd12, 16'h0003, 16'h0005);
    n_total++;
    if (obs() !== {16'h5555, 4'b1010, 1'b1})
      $display("FAIL cmp_flags: got %h want %h", obs(), {16'h5555, 4'b1010, 1'b1});
    else n_pass++;
    issue(5'd13, 16'h00F0, 16'h0F00);
    n_total++;
    if (obs() !== {16'h5555, 4'b0100, 1'b1})
      $display("FAIL test_flags: got %h want %h", obs(), {16'h5555, 4'b0100, 1'b1});
    else n_pass++;
    issue(5'd20, 16'h1111, 16'h2222);
    n_total++;
    if ({obs(), bus.busy} !== {16'h5555, 4'b0100, 1'b1, 1'b0})
      $display("FAIL noop20: got %h want %h", {obs(), bus.busy}, {16'h5555, 4'b0100, 1'b1, 1'b0});
    else n_pass++;
  endtask

  task automatic run_mul(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic [20:0] exp, input string nm);
    int cyc;
    issue(op, a, b);
    n_total++;
    if (bus.busy !== 1'b1) $display("FAIL %s_busy: got %b want 1", nm, bus.busy);
    else n_pass++;
    // Ignored request with different operands while busy
    bus.aluOp = 5'd1; bus.A = 16'h0001; bus.B = 16'h0001; bus.execute = 1'b1;
    wait_done(cyc);
    bus.execute = 1'b0;
    n_total++;
    if (cyc !== 16 || bus.busy !== 1'b0)
      $display("FAIL %s_latency: got %0d cycles busy=%b want 16 cycles busy=0", nm, cyc, bus.busy);
    else n_pass++;
    n_total++;
    if (obs() !== exp) $display("FAIL %s_result: got %h want %h", nm, obs(), exp);
    else n_pass++;
  endtask

  task automatic test_mul();
    run_mul(5'd8, 16'd300, 16'd300, {16'h5F90, 4'b0000, 1'b1}, "mul");
    run_mul(5'd9, 16'd300, 16'd300, {16'h0001, 4'b0000, 1'b1}, "mulhu");
    run_mul(5'd9, 16'hFFFF, 16'hFFFF, {16'hFFFE, 4'b0010, 1'b1}, "mulhu_max");
  endtask

  task automatic test_back_to_back();
    int cyc;
    issue(5'd8, 16'h0003, 16'h0004);
    wait_done(cyc);
    issue(5'd1, 16'h0010, 16'h0020);
    n_total++;
    if (obs() !== {16'h0030, 4'b0000, 1'b1})
      $display("FAIL back_to_back: got %h want %h", obs(), {16'h0030, 4'b0000, 1'b1});
    else n_pass++;
  endtask

  task automatic test_div();
    int cyc;
`ifdef ALU_MULDIV_DIV_EN
    logic [4:0]  ops [5] = '{5'd10, 5'd11, 5'd10, 5'd11, 5'd11};
    logic [15:0] av  [5] = '{16'd100, 16'd100, 16'd5, 16'd5, 16'hFFFF};
    logic [15:0] bv  [5] = '{16'd7, 16'd7, 16'd0, 16'd0, 16'h8001};
    logic [20:0] ex  [5] = '{{16'h000E, 4'b0000, 1'b1}, {16'h0002, 4'b0000, 1'b1},
                             {16'hFFFF, 4'b0011, 1'b1}, {16'h0005, 4'b0001, 1'b1},
                             {16'h7FFE, 4'b0000, 1'b1}};
    for (int i = 0; i < 5; i++) begin
      issue(ops[i], av[i], bv[i]);
      wait_done(cyc);
      n_total++;
      if (cyc !== 16 || obs() !== ex[i])
        $display("FAIL div%0d: got %h after %0d cycles want %h after 16", i, obs(), cyc, ex[i]);
      else n_pass++;
    end
`else
    issue(5'd0, 16'h0000, 16'h4321);
    issue(5'd10, 16'd5, 16'd0);
    n_total++;
    if ({obs(), bus.busy} !== {16'h4321, 4'b0000, 1'b1, 1'b0})
      $display("FAIL divu_noop: got %h want %h", {obs(), bus.busy}, {16'h4321, 4'b0000, 1'b1, 1'b0});
    else n_pass++;
    issue(5'd11, 16'd100, 16'd7);
    n_total++;
    if ({obs(), bus.busy} !== {16'h4321, 4'b0000, 1'b1, 1'b0})
      $display("FAIL remu_noop: got %h want %h", {obs(), bus.busy}, {16'h4321, 4'b0000, 1'b1, 1'b0});
    else n_pass++;
    cyc = 0;
`endif
  endtask

  task automatic test_reset_mid();
    issue(5'd0, 16'h0000, 16'hBEEF);
    issue(5'd8, 16'd300, 16'd300);
    repeat (4) @(posedge CLK);
    #2 RSTb = 1'b0;
    #1;
    n_total++;
    if ({obs(), bus.busy} !== 22'h0)
      $display("FAIL reset_async: got %h want %h", {obs(), bus.busy}, 22'h0);
    else n_pass++;
    repeat (2) @(posedge CLK);
    @(negedge CLK); RSTb = 1'b1;
    issue(5'd1, 16'h0002, 16'h0003);
    n_total++;
    if ({obs(), bus.busy} !== {16'h0005, 4'b0000, 1'b1, 1'b0})
      $display("FAIL reset_first_accept: got %h want %h", {obs(), bus.busy}, {16'h0005, 4'b0000, 1'b1, 1'b0});
    else n_pass++;
  endtask

  initial begin
    bus.A = '0; bus.B = '0; bus.aluOp = '0; bus.execute = 1'b0;
    test_reset();
    test_add();
    test_overflow();
    test_carry();
    test_logic();
    test_cmp_test_noop();
    test_mul();
    test_back_to_back();
    test_div();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/alu_muldiv.md
ALU_MULDIV -- requirements
Module: alu_muldiv

Interface
REQ-001 Parameter WIDTH, default 16, datapath width in bits; legal values 8..32.
REQ-002 CLK  input  1  system clock; all state updates on rising edge.
REQ-003 RSTb  input  1  reset, asynchronous, active-low.
REQ-004 A  input  WIDTH  operand A.
REQ-005 B  input  WIDTH  operand B.
REQ-006 aluOp  input  5  operation select.
REQ-007 execute  input  1  start request; sampled only while busy=0.
REQ-008 aluOut  output  WIDTH  registered result.
REQ-009 C, Z, S, V  output  1 each  registered carry/borrow, zero, sign, signed-overflow flags.
REQ-010 busy  output  1  multi-cycle operation in progress.
REQ-011 done  output  1  one-cycle pulse: aluOut/flags updated this cycle.

Function
REQ-012 Opcodes: 0 MOV (B), 1 ADD, 2 ADC, 3 SUB (A-B), 4 SBB, 5 AND, 6 OR, 7 XOR, 8 MUL (low WIDTH of unsigned A*B), 9 MULHU (high WIDTH), 10 DIVU (quotient), 11 REMU (remainder), 12 CMP (SUB flags only), 13 TEST (AND flags only); 14-31 no-op.
REQ-013 Accept: rising edge with execute=1, busy=0; otherwise edge has no effect on aluOut/flags.
REQ-014 Single-cycle ops (0-7, 12, 13) register result and flags at the accept edge; done=1 for the following cycle.
REQ-015 CMP/TEST update flags only; aluOut holds its previous value.
REQ-016 No-op opcodes: accepted, aluOut and flags unchanged, done still pulses.
REQ-017 ADC uses carry-in = current C; SBB subtracts current C as borrow-in.
REQ-018 ADD/ADC: C = carry-out of bit WIDTH-1; SUB/SBB/CMP: C = 1 when unsigned borrow occurs.
REQ-019 V = signed overflow for add/sub family; V=0 for MOV, logic ops, MUL, MULHU.
REQ-020 Z = (result==0), S = result[WIDTH-1] for every op that updates flags; C=0 for MOV, logic ops, MUL, MULHU, DIVU, REMU.
REQ-021 MUL/MULHU: iterative shift-add, one partial product per cycle; busy=1 from accept edge until edge accept+WIDTH, at which result registers, busy clears, done pulses for the next cycle.
REQ-022 DIVU/REMU: restoring division, one quotient bit per cycle, same WIDTH-cycle timing as REQ-021.
REQ-023 Divide by zero: quotient all-ones, remainder = A, V=1; timing unchanged.
REQ-024 execute, A, B, aluOp ignored while busy=1; operands captured at accept edge.
REQ-025 Control FSM states IDLE, MUL, DIV; IDLE->MUL/DIV on accept of multi-cycle op; MUL/DIV->IDLE when iteration counter reaches WIDTH-1.
REQ-026 Back-to-back: a new accept permitted on the edge immediately after busy falls.

Reset
REQ-027 RSTb=0 forces aluOut=0, C=Z=S=V=0, busy=0, done=0, FSM=IDLE, counter=0 immediately, including mid-operation; the in-flight operation is discarded.
REQ-028 First accept possible on first rising edge after RSTb deasserts.

Configuration
REQ-029 Macro ALU_MULDIV_DIV_EN: defined -> DIVU/REMU implemented per REQ-022/023; undefined -> opcodes 10/11 behave as no-op (REQ-016), DIV state and divider logic absent.

Verification
REQ-030 WIDTH=16, ADD A=5, B=0xFFF9 -> next cycle aluOut=0xFFFE, S=1, C=0, Z=0, V=0, done=1.
REQ-031 ADD 0x7FFF+0x7FFF -> 0xFFFE, V=1, S=1, C=0; then SUB 0x7FFF-0x8000 -> 0xFFFF, V=1, C=1.
REQ-032 MUL 300*300 -> busy high 16 cycles, aluOut=0x5F90; MULHU same operands -> 0x0001; execute pulses during busy ignored.
REQ-033 DIVU 100/7 -> 0x000E; REMU -> 0x0002; DIVU 5/0 -> 0xFFFF, V=1 (with macro); without macro -> aluOut unchanged.
REQ-034 ADD 0xFFFF+0x0001 (C=1, Z=1) then ADC 0+0 -> aluOut=0x0001, C=0.
REQ-035 RSTb low 5 cycles into MUL -> aluOut=0, busy=0, flags 0 asynchronously; new ADD accepted after release.
